flash_sample_reader: RTL and testbench
======================================

# flash_sample_reader

Downstream of the address handler. Accepts a one-cycle start pulse with a 23-bit flash word address, performs one Avalon-MM read of the 32-bit word from flash, and presents the two 16-bit audio samples it contains to the audio path, one per sample tick. When both samples have been output, it returns a one-cycle finish pulse so that the address handler can advance.

## Interface
Parameters:
- FLASH_AW, 23, flash word address width.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for readdatavalid (used only with the macro).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the address handler.
- address  in  FLASH_AW  word address; valid with start.
- backwards  in  1  playback direction; sampled with start.
- sample_tick  in  1  one-cycle audio-rate strobe.
- flash_mem_read  out  1  Avalon read request.
- flash_mem_address  out  FLASH_AW  Avalon address.
- flash_mem_byteenable  out  4  constant 4'hF.
- flash_mem_waitrequest  in  1  slave stall.
- flash_mem_readdata  in  32  read data.
- flash_mem_readdatavalid  in  1  read data qualifier.
- audio_data  out  16  current sample; held between emits.
- sample_valid  out  1  one-cycle pulse when audio_data updates.
- finish  out  1  one-cycle pulse; word fully consumed.
- timeout_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, WAIT_DATA, WAIT_TICK0, WAIT_TICK1, DONE.
- IDLE: when start=1, register address into flash_mem_address and latch backwards, then go to REQ. All other inputs are ignored.
- REQ: flash_mem_read=1. When waitrequest=0, the request is accepted; go to WAIT_DATA and drop read on the next cycle.
- WAIT_DATA: when readdatavalid=1, latch readdata into a 32-bit word register and go to WAIT_TICK0.
- WAIT_TICK0: on sample_tick, output the first half of the word: readdata[15:0] when forward, readdata[31:16] when backwards. Pulse sample_valid and go to WAIT_TICK1.
- WAIT_TICK1: on sample_tick, output the other half, pulse sample_valid and go to DONE.
- DONE: finish=1 for exactly one cycle, then go to IDLE.
- Ignored inputs:
  - start outside IDLE.
  - readdatavalid outside WAIT_DATA.
  - sample_tick outside WAIT_TICK0 and WAIT_TICK1. Ticks are never queued.
- audio_data is passed through unmodified as a 16-bit two's-complement value. There is no arithmetic on the sample.
- Address values are not range-checked; range and wrap handling belongs to the address handler.

## Timing
- Reset values: state=IDLE; flash_mem_read=0, flash_mem_address=0, audio_data=0, sample_valid=0, finish=0, timeout_err=0. flash_mem_byteenable is always 4'hF.
- Reset asserted mid-transfer drops read at once, abandons the word and produces no finish.
- All outputs are registered.
- With start at cycle 0:
  - read=1 from cycle 1.
  - With zero waitrequest and readdatavalid at cycle 2, the word is latched and WAIT_TICK0 is entered at cycle 3.
- A tick seen at cycle t in a WAIT_TICK state produces sample_valid=1 and the new audio_data at t+1.
- finish follows one cycle after the second sample_valid.
- Best-case start→finish: 6 cycles.
- flash_mem_address is stable from REQ until the next start.

## Configuration
- FLASH_TIMEOUT_EN defined:
  - A counter runs in WAIT_DATA.
  - After TIMEOUT_CYCLES cycles without readdatavalid, latch 32'h0 and go to WAIT_TICK0 (two silent samples).
  - Set timeout_err; it clears only on reset.
- FLASH_TIMEOUT_EN undefined:
  - The block waits indefinitely in WAIT_DATA.
  - timeout_err is tied to 0.

## Structure
- Package flash_reader_pkg: state enum, BYTEENABLE_ALL=4'hF, default FLASH_AW.
- One sub-module: flash_timeout_counter (load/enable/expired), instantiated only under FLASH_TIMEOUT_EN.

## Test plan
- Forward read:
  - Stimulus: start with address=23'h000010, backwards=0; readdata=32'hBEEF_1234; two ticks.
  - Required: flash_mem_address=23'h000010; audio_data 16'h1234 then 16'hBEEF; finish 1 cycle after the second sample_valid.
- Backwards read:
  - Stimulus: same word with backwards=1.
  - Required: 16'hBEEF then 16'h1234.
- Waitrequest stall:
  - Stimulus: waitrequest held high for 5 cycles.
  - Required: read and address stable throughout; exactly one accepted read.
- Ignored events:
  - Stimulus: start pulsed in WAIT_TICK0; tick in WAIT_DATA.
  - Required: no new read; the tick is not consumed; sample order is unchanged.
- Reset mid-op:
  - Stimulus: rst low in WAIT_DATA.
  - Required: all outputs 0 immediately; no finish; a fresh start afterwards behaves normally.
- Timeout (FLASH_TIMEOUT_EN):
  - Stimulus: no readdatavalid.
  - Required: after 255 cycles, timeout_err=1 and two zero samples, then finish.

Source files
------------

// File: rtl/flash_sample_reader_pkg.sv
// Shared types and constants for the flash sample reader.
package flash_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA,
        ST_WAIT_TICK0,
        ST_WAIT_TICK1,
        ST_DONE
    } state_e;

    localparam logic [3:0] BYTEENABLE_ALL         = 4'hF;
    localparam int         FLASH_AW_DEFAULT       = 23;
    localparam int         TIMEOUT_CYCLES_DEFAULT = 255;

    function automatic logic [15:0] pick_half(input logic [31:0] word, input logic upper);
        return upper ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-only bus between the sample reader (master) and flash (slave).
interface flash_sample_reader_if
    import flash_reader_pkg::*;
#(
    parameter int FLASH_AW = FLASH_AW_DEFAULT
) ();

    logic                read;
    logic [FLASH_AW-1:0] address;
    logic [3:0]          byteenable;
    logic                waitrequest;
    logic [31:0]         readdata;
    logic                readdatavalid;

    modport master (
        output read, address, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, address, byteenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/flash_sample_reader_timeout.sv
// Down-counter that flags when readdatavalid has been missing for TIMEOUT_CYCLES cycles.
module flash_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The first waiting cycle sees LOAD_VAL, so zero marks the last allowed cycle.
    assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/flash_sample_reader.sv
// Reads one 32-bit flash word and emits its two 16-bit samples on sample ticks.
// Optional FLASH_TIMEOUT_EN: bounded wait for readdatavalid with sticky timeout_err.
module flash_sample_reader
    import flash_reader_pkg::*;
#(
    parameter int FLASH_AW       = FLASH_AW_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FLASH_AW-1:0]   address,
    input  logic                  backwards,
    input  logic                  sample_tick,
    flash_sample_reader_if.master flash_mem,
    output logic [15:0]           audio_data,
    output logic                  sample_valid,
    output logic                  finish,
    output logic                  timeout_err
);

    state_e              state_q, state_d;
    logic                read_q, read_d;
    logic [FLASH_AW-1:0] addr_q, addr_d;
    logic                back_q, back_d;
    logic [31:0]         word_q, word_d;
    logic [15:0]         audio_q, audio_d;
    logic                sv_q, sv_d;
    logic                fin_q, fin_d;
    logic                terr_q, terr_d;
    logic                tmo_expired;

`ifdef FLASH_TIMEOUT_EN
    flash_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (state_q == ST_REQ),
        .enable  (state_q == ST_WAIT_DATA),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        addr_d  = addr_q;
        back_d  = back_q;
        word_d  = word_q;
        audio_d = audio_q;
        sv_d    = 1'b0;
        fin_d   = 1'b0;
        terr_d  = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = address;
                    back_d  = backwards;
                    read_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!flash_mem.waitrequest) begin
                    read_d  = 1'b0;
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (flash_mem.readdatavalid) begin
                    word_d  = flash_mem.readdata;
                    state_d = ST_WAIT_TICK0;
                end else if (tmo_expired) begin
                    word_d  = 32'h0;
                    terr_d  = 1'b1;
                    state_d = ST_WAIT_TICK0;
                end
            end
            ST_WAIT_TICK0: begin
                if (sample_tick) begin
                    audio_d = pick_half(word_q, back_q);
                    sv_d    = 1'b1;
                    state_d = ST_WAIT_TICK1;
                end
            end
            ST_WAIT_TICK1: begin
                if (sample_tick) begin
                    audio_d = pick_half(word_q, !back_q);
                    sv_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fin_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            read_q  <= 1'b0;
            addr_q  <= '0;
            back_q  <= 1'b0;
            word_q  <= 32'h0;
            audio_q <= 16'h0;
            sv_q    <= 1'b0;
            fin_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            back_q  <= back_d;
            word_q  <= word_d;
            audio_q <= audio_d;
            sv_q    <= sv_d;
            fin_q   <= fin_d;
            terr_q  <= terr_d;
        end
    end

    assign flash_mem.read       = read_q;
    assign flash_mem.address    = addr_q;
    assign flash_mem.byteenable = BYTEENABLE_ALL;
    assign audio_data           = audio_q;
    assign sample_valid         = sv_q;
    assign finish               = fin_q;
    assign timeout_err          = terr_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Scoreboard bench: expected samples are queued at start and popped on sample_valid.
module tb_flash_sample_reader;

    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] address = '0;
    logic          backwards = 1'b0;
    logic          sample_tick = 1'b0;
    logic [15:0]   audio_data;
    logic          sample_valid;
    logic          finish;
    logic          timeout_err;

    flash_sample_reader_if #(.FLASH_AW(AW)) bus ();

    flash_sample_reader #(
        .FLASH_AW       (AW),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .address      (address),
        .backwards    (backwards),
        .sample_tick  (sample_tick),
        .flash_mem    (bus),
        .audio_data   (audio_data),
        .sample_valid (sample_valid),
        .finish       (finish),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          accepts = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic        prev_sv = 1'b0;

    always @(posedge clk) begin
        if (rst && bus.read && !bus.waitrequest) accepts++;
    end

    always @(negedge clk) begin
        if (rst && sample_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample_unexpected got %h, none required", audio_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (audio_data !== mon_exp) begin
                    errors++;
                    $display("FAIL sample_value got %h required %h", audio_data, mon_exp);
                end
            end
        end
        if (rst && finish) begin
            checks++;
            if (prev_sv !== 1'b1) begin
                errors++;
                $display("FAIL finish_align got finish without sample_valid one cycle earlier");
            end
        end
        prev_sv = sample_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a, input logic b, input logic [31:0] w,
                               input bit push);
        address   = a;
        backwards = b;
        start     = 1'b1;
        if (push) begin
            exp_q.push_back(b ? w[31:16] : w[15:0]);
            exp_q.push_back(b ? w[15:0] : w[31:16]);
        end
        step();
        start     = 1'b0;
        address   = AW'($urandom);
        backwards = 1'($urandom);
    endtask

    task automatic serve_read(input int stall, input int dly, input logic [31:0] w,
                              input bit tick_in_wait, output int rd_cycles,
                              output bit addr_ok, output bit seen);
        int            n = 0;
        logic [AW-1:0] a0;
        seen = 1'b0;
        rd_cycles = 0;
        addr_ok = 1'b1;
        while (!bus.read && n < 20) begin
            step();
            n++;
        end
        if (!bus.read) return;
        seen = 1'b1;
        a0 = bus.address;
        bus.waitrequest = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (bus.read) rd_cycles++;
            if (bus.address !== a0) addr_ok = 1'b0;
            step();
        end
        bus.waitrequest = 1'b0;
        if (bus.read) rd_cycles++;
        if (bus.address !== a0) addr_ok = 1'b0;
        step();
        if (bus.read) rd_cycles++;
        for (int i = 0; i < dly; i++) begin
            sample_tick = tick_in_wait && (i == 0);
            step();
            sample_tick = 1'b0;
            if (bus.read) rd_cycles++;
        end
        bus.readdatavalid = 1'b1;
        bus.readdata = w;
        step();
        bus.readdatavalid = 1'b0;
        bus.readdata = $urandom;
    endtask

    task automatic run_ticks(input int gap, output int fin_delay);
        for (int k = 0; k < 2; k++) begin
            repeat (gap) step();
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
        end
        fin_delay = -1;
        for (int i = 0; i < 4; i++) begin
            if (finish) begin
                fin_delay = i;
                break;
            end
            step();
        end
        if (fin_delay >= 0) step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.read, bus.address, audio_data, sample_valid, finish, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b addr=%h aud=%h sv=%b fin=%b terr=%b required all 0",
                     bus.read, bus.address, audio_data, sample_valid, finish, timeout_err);
        end
        checks++;
        if (bus.byteenable !== 4'hF) begin
            errors++;
            $display("FAIL byteenable got %h required f", bus.byteenable);
        end
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_forward();
        int rc, fd, acc0;
        bit ok, seen;
        acc0 = accepts;
        pulse_start(23'h000010, 1'b0, 32'hBEEF_1234, 1'b1);
        checks++;
        if (bus.read !== 1'b1 || bus.address !== 23'h000010) begin
            errors++;
            $display("FAIL fwd_request got rd=%b addr=%h required 1 000010", bus.read, bus.address);
        end
        serve_read(0, 0, 32'hBEEF_1234, 1'b0, rc, ok, seen);
        checks++;
        if (!seen || rc != 1) begin
            errors++;
            $display("FAIL fwd_read_cycles got seen=%b cycles=%0d required 1 1", seen, rc);
        end
        run_ticks(0, fd);
        checks++;
        if (fd != 1) begin
            errors++;
            $display("FAIL fwd_finish_delay got %0d required 1", fd);
        end
        checks++;
        if (audio_data !== 16'hBEEF || finish !== 1'b0) begin
            errors++;
            $display("FAIL fwd_hold got aud=%h fin=%b required beef 0", audio_data, finish);
        end
        checks++;
        if (accepts - acc0 != 1 || exp_q.size() != 0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL fwd_totals got acc=%0d left=%0d terr=%b required 1 0 0",
                     accepts - acc0, exp_q.size(), timeout_err);
        end
    endtask

    task automatic test_backwards();
        int rc, fd;
        bit ok, seen;
        pulse_start(23'h7FFFFF, 1'b1, 32'hBEEF_1234, 1'b1);
        serve_read(0, 1, 32'hBEEF_1234, 1'b0, rc, ok, seen);
        step();
        checks++;
        if (sample_valid !== 1'b0 || audio_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL bwd_idle_tick got sv=%b aud=%h required 0 beef", sample_valid, audio_data);
        end
        run_ticks(3, fd);
        checks++;
        if (fd != 1 || bus.address !== 23'h7FFFFF || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bwd_done got fd=%0d addr=%h left=%0d required 1 7fffff 0",
                     fd, bus.address, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int rc, fd, acc0;
        bit ok, seen;
        acc0 = accepts;
        pulse_start(23'h00ABCD, 1'b0, 32'h8000_7FFF, 1'b1);
        serve_read(5, 0, 32'h8000_7FFF, 1'b0, rc, ok, seen);
        checks++;
        if (!seen || rc != 6 || !ok) begin
            errors++;
            $display("FAIL stall_hold got seen=%b cycles=%0d addr_stable=%b required 1 6 1", seen, rc, ok);
        end
        checks++;
        if (accepts - acc0 != 1) begin
            errors++;
            $display("FAIL stall_accepts got %0d required 1", accepts - acc0);
        end
        run_ticks(2, fd);
        checks++;
        if (fd != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_done got fd=%0d left=%0d required 1 0", fd, exp_q.size());
        end
    endtask

    task automatic test_ignored();
        int rc, fd, acc0;
        bit ok, seen;
        acc0 = accepts;
        pulse_start(23'h000123, 1'b1, 32'h0102_A5A5, 1'b1);
        serve_read(0, 3, 32'h0102_A5A5, 1'b1, rc, ok, seen);
        address = 23'h555555;
        start = 1'b1;
        bus.readdatavalid = 1'b1;
        bus.readdata = 32'hDEAD_0000;
        step();
        start = 1'b0;
        bus.readdatavalid = 1'b0;
        step();
        checks++;
        if (bus.read !== 1'b0 || bus.address !== 23'h000123 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL ign_start got rd=%b addr=%h sv=%b required 0 000123 0",
                     bus.read, bus.address, sample_valid);
        end
        run_ticks(0, fd);
        checks++;
        if (fd != 1 || exp_q.size() != 0 || accepts - acc0 != 1) begin
            errors++;
            $display("FAIL ign_done got fd=%0d left=%0d acc=%0d required 1 0 1",
                     fd, exp_q.size(), accepts - acc0);
        end
    endtask

    task automatic test_reset_midop();
        int rc, fd, fin_cnt;
        bit ok, seen;
        pulse_start(23'h000200, 1'b0, 32'h1111_2222, 1'b0);
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.read, bus.address, audio_data, sample_valid, finish} !== '0) begin
            errors++;
            $display("FAIL midop_reset got rd=%b addr=%h aud=%h sv=%b fin=%b required all 0",
                     bus.read, bus.address, audio_data, sample_valid, finish);
        end
        bus.readdatavalid = 1'b1;
        bus.readdata = 32'h1111_2222;
        step();
        bus.readdatavalid = 1'b0;
        step();
        rst = 1'b1;
        fin_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            if (finish || sample_valid) fin_cnt++;
        end
        checks++;
        if (fin_cnt != 0) begin
            errors++;
            $display("FAIL midop_no_finish got %0d pulses required 0", fin_cnt);
        end
        pulse_start(23'h000201, 1'b0, 32'hFFFF_0001, 1'b1);
        serve_read(0, 0, 32'hFFFF_0001, 1'b0, rc, ok, seen);
        run_ticks(1, fd);
        checks++;
        if (!seen || fd != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midop_recover got seen=%b fd=%0d left=%0d required 1 1 0",
                     seen, fd, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int fd;
`ifdef FLASH_TIMEOUT_EN
        pulse_start(23'h000300, 1'b0, 32'h0, 1'b1);
        step();
        repeat (254) step();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early got %b required 0 at cycle 254 of wait", timeout_err);
        end
        step();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_set got %b required 1 after 255 cycles", timeout_err);
        end
        run_ticks(0, fd);
        checks++;
        if (fd != 1 || timeout_err !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL tmo_done got fd=%0d terr=%b left=%0d required 1 1 0",
                     fd, timeout_err, exp_q.size());
        end
`else
        pulse_start(23'h000300, 1'b0, 32'h7654_3210, 1'b1);
        step();
        repeat (300) step();
        checks++;
        if (timeout_err !== 1'b0 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL notmo_wait got terr=%b sv=%b required 0 0", timeout_err, sample_valid);
        end
        bus.readdatavalid = 1'b1;
        bus.readdata = 32'h7654_3210;
        step();
        bus.readdatavalid = 1'b0;
        run_ticks(0, fd);
        checks++;
        if (fd != 1 || exp_q.size() != 0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL notmo_done got fd=%0d left=%0d terr=%b required 1 0 0",
                     fd, exp_q.size(), timeout_err);
        end
`endif
    endtask

    initial begin
        bus.waitrequest   = 1'b0;
        bus.readdata      = 32'h0;
        bus.readdatavalid = 1'b0;
        test_reset();
        test_forward();
        test_backwards();
        test_stall();
        test_ignored();
        test_reset_midop();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
